cache_sequencer: RTL
====================

# cache_sequencer

Upstream command stage for the cache. It buffers cache commands from the trace/command source in a small FIFO and issues them one at a time as the master side of the cache's 4-phase request/valid handshake. It captures the returned data and evict flag, returns one response per command over a ready/valid port, and keeps transaction statistics.

## Interface
Parameters:
- DATAWIDTH, 8, cache data bus width
- ADDRESSWIDTH, 32, cache address width
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- TIMEOUT, 255, max cycles to wait for valid after request rises (≥1)

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_op  in  4  operation (cachepkg inst_t encoding)
- cmd_addr  in  ADDRESSWIDTH  command address
- cmd_data  in  DATAWIDTH  write data (used only for op 1)
- operation  out  4  op presented to cache
- addr  out  ADDRESSWIDTH  address presented to cache
- data_o  out  DATAWIDTH  write data presented to cache
- data_oe  out  1  drive enable for the shared data bus
- data_i  in  DATAWIDTH  data returned by cache
- request  out  1  4-phase request
- valid  in  1  4-phase acknowledge from cache
- evict  in  1  cache evicted a line (sampled with valid)
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_op, rsp_addr  out  4 / ADDRESSWIDTH  echo of issued command
- rsp_data  out  DATAWIDTH  captured data_i (reads); 0 otherwise
- rsp_evict  out  1  captured evict
- rsp_err  out  1  transaction timed out
- stat_reads, stat_writes, stat_evicts, stat_timeouts  out  32 each  wrapping counters

## Operation
- Op classes: 1 = write (drives data); 0 and 2 = read (captures data_i); all other codes = control (no data driven or captured, rsp_data = 0).
- FIFO: push when cmd_valid && cmd_ready; cmd_ready = !full. Pointers wrap modulo DEPTH. Push into a full FIFO is impossible by construction. Push and pop in the same cycle are both honoured and leave the count unchanged.
- FSM states IDLE, REQ, REL, RSP.
  - IDLE: if FIFO non-empty, pop the head. Load operation/addr/data_o, set data_oe = (op==1) and request = 1, go to REQ.
  - REQ: if valid=1, capture data_i (read class only) and evict, set request = 0 and data_oe = 0, go to REL. Otherwise, if the wait counter reaches TIMEOUT, set err, request = 0 and data_oe = 0, go to REL.
  - REL: wait for valid = 0, then set rsp_valid = 1 and go to RSP.
  - RSP: hold all rsp_* stable. When rsp_ready = 1, clear rsp_valid and go to IDLE.
- Counter updates happen on RSP exit:
  - stat_reads increments for read class.
  - stat_writes increments for op 1.
  - stat_evicts increments when rsp_evict = 1.
  - stat_timeouts increments when rsp_err = 1.
- Counters wrap at 2^32.
- Only one transaction is in flight at a time. Commands arriving meanwhile queue in the FIFO.

## Timing
- Reset values: every output is 0 except cmd_ready = 1. This covers request, data_oe, rsp_valid, all rsp_*, and all stat_*. FIFO is empty, FSM is in IDLE, wait counter is 0.
- Reset asserted mid-transaction: request drops asynchronously and FIFO contents are discarded. No response is produced for lost commands.
- All outputs are registered.
- Latency: a command accepted at edge 0 into an empty FIFO gives request = 1 after edge 1, because the IDLE pop happens at edge 1.
- The wait counter clears on REQ entry and increments each REQ cycle with valid = 0. Timeout fires at the edge where the count equals TIMEOUT, so request is high for TIMEOUT+1 cycles.
- valid is sampled only in REQ and REL. valid already high on REQ entry counts as acknowledge at the first REQ edge.
- Minimum transaction with a zero-latency cache and rsp_ready held at 1: IDLE, REQ, REL, RSP = 4 cycles. Next request rises 1 cycle after RSP exit.
- operation/addr/data_o stay stable from request rise until the next IDLE pop.

## Test plan
- Single write: op 1, addr 0x0000_0040, data 0xA5; cache asserts valid 3 cycles after request. Required: data_oe = 1 with data_o = 0xA5 while request is high. Response has rsp_op = 1, rsp_data = 0, rsp_err = 0, and stat_writes = 1.
- Read with evict: op 0, addr 0x1234_5678; cache returns data_i = 0x3C with evict = 1. Required: rsp_data = 0x3C, rsp_evict = 1, stat_reads = 1, stat_evicts = 1.
- Back-pressure/full: push 6 commands with DEPTH = 4, rsp_ready held at 0, cache stalled. Required: cmd_ready = 0 after 5 accepts (4 in FIFO + 1 issued). Responses come out in order once rsp_ready = 1.
- Timeout: TIMEOUT = 255, valid never asserted. Required: request high for exactly 256 cycles, then response with rsp_err = 1 and stat_timeouts = 1. The next command issues normally.
- Control op: op 3. Required: data_oe stays 0, rsp_data = 0, no stats change except stat_evicts if evict was set.
- Reset mid-REQ: assert reset while request = 1 with 2 commands queued. Required: all outputs go to reset values immediately and cmd_ready = 1. No rsp_valid appears after reset deasserts.

Source files
------------

// File: rtl/cache_sequencer.sv
// Upstream command stage for the cache: FIFO-buffered commands issued over a 4-phase
// request/valid handshake, with one ready/valid response per command and statistics.
module cache_sequencer #(
    parameter int unsigned DATAWIDTH    = 8,
    parameter int unsigned ADDRESSWIDTH = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [3:0]              cmd_op,
    input  logic [ADDRESSWIDTH-1:0] cmd_addr,
    input  logic [DATAWIDTH-1:0]    cmd_data,
    output logic [3:0]              operation,
    output logic [ADDRESSWIDTH-1:0] addr,
    output logic [DATAWIDTH-1:0]    data_o,
    output logic                    data_oe,
    input  logic [DATAWIDTH-1:0]    data_i,
    output logic                    request,
    input  logic                    valid,
    input  logic                    evict,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [3:0]              rsp_op,
    output logic [ADDRESSWIDTH-1:0] rsp_addr,
    output logic [DATAWIDTH-1:0]    rsp_data,
    output logic                    rsp_evict,
    output logic                    rsp_err,
    output logic [31:0]             stat_reads,
    output logic [31:0]             stat_writes,
    output logic [31:0]             stat_evicts,
    output logic [31:0]             stat_timeouts
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned EW = 4 + ADDRESSWIDTH + DATAWIDTH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] REL  = 2'd2;
    localparam logic [1:0] RSP  = 2'd3;

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          push, pop;
    logic [EW-1:0] head;
    logic [3:0]    head_op;

    logic [1:0]              state_q, state_d;
    logic [3:0]              op_q, op_d;
    logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
    logic [DATAWIDTH-1:0]    wdata_q, wdata_d;
    logic                    data_oe_q, data_oe_d;
    logic                    request_q, request_d;
    logic [WW-1:0]           wait_q, wait_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATAWIDTH-1:0]    rsp_data_q, rsp_data_d;
    logic                    rsp_evict_q, rsp_evict_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [31:0]             reads_q, reads_d, writes_q, writes_d;
    logic [31:0]             evicts_q, evicts_d, tmo_q, tmo_d;
    logic                    op_is_read;

    assign head       = mem_q[rd_ptr_q];
    assign head_op    = head[EW-1 -: 4];
    assign op_is_read = (op_q == 4'd0) || (op_q == 4'd2);

    // cmd_ready is registered from the next count, so a push can never hit a full FIFO
    always_comb begin
        push        = cmd_valid && cmd_ready_q;
        pop         = (state_q == IDLE) && (count_q != '0);
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d     = count_q;
        if (push && !pop) count_d = count_q + CW'(1);
        if (pop && !push) count_d = count_q - CW'(1);
        cmd_ready_d = (count_d != CW'(DEPTH));
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        data_oe_d   = data_oe_q;
        request_d   = request_q;
        wait_d      = wait_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_evict_d = rsp_evict_q;
        rsp_err_d   = rsp_err_q;
        reads_d     = reads_q;
        writes_d    = writes_q;
        evicts_d    = evicts_q;
        tmo_d       = tmo_q;
        case (state_q)
            IDLE: if (pop) begin
                op_d        = head_op;
                addr_d      = head[DATAWIDTH +: ADDRESSWIDTH];
                wdata_d     = head[DATAWIDTH-1:0];
                data_oe_d   = (head_op == 4'd1);
                request_d   = 1'b1;
                wait_d      = '0;
                rsp_data_d  = '0;
                rsp_evict_d = 1'b0;
                rsp_err_d   = 1'b0;
                state_d     = REQ;
            end
            REQ: begin
                if (valid) begin
                    if (op_is_read) rsp_data_d = data_i;
                    rsp_evict_d = evict;
                    request_d   = 1'b0;
                    data_oe_d   = 1'b0;
                    state_d     = REL;
                end else if (wait_q == WW'(TIMEOUT)) begin
                    rsp_err_d = 1'b1;
                    request_d = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = REL;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            REL: if (!valid) begin
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            default: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
                if (op_is_read)       reads_d  = reads_q + 32'd1;
                if (op_q == 4'd1)     writes_d = writes_q + 32'd1;
                if (rsp_evict_q)      evicts_d = evicts_q + 32'd1;
                if (rsp_err_q)        tmo_d    = tmo_q + 32'd1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_addr, cmd_data};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            data_oe_q   <= 1'b0;
            request_q   <= 1'b0;
            wait_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_evict_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            reads_q     <= '0;
            writes_q    <= '0;
            evicts_q    <= '0;
            tmo_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmd_ready_q <= cmd_ready_d;
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            data_oe_q   <= data_oe_d;
            request_q   <= request_d;
            wait_q      <= wait_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_evict_q <= rsp_evict_d;
            rsp_err_q   <= rsp_err_d;
            reads_q     <= reads_d;
            writes_q    <= writes_d;
            evicts_q    <= evicts_d;
            tmo_q       <= tmo_d;
        end
    end

    // The issued command registers double as the response echo; they only change on the next pop
    assign cmd_ready     = cmd_ready_q;
    assign operation     = op_q;
    assign addr          = addr_q;
    assign data_o        = wdata_q;
    assign data_oe       = data_oe_q;
    assign request       = request_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_op        = op_q;
    assign rsp_addr      = addr_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_evict     = rsp_evict_q;
    assign rsp_err       = rsp_err_q;
    assign stat_reads    = reads_q;
    assign stat_writes   = writes_q;
    assign stat_evicts   = evicts_q;
    assign stat_timeouts = tmo_q;

endmodule
